// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm stage: settable BCD alarm time with ring/snooze FSM and buzzer beat
module alarm_ctrl #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       sec_tick,
    input  logic [3:0] hour_h,
    input  logic [3:0] hour_l,
    input  logic [3:0] minute_h,
    input  logic [3:0] minute_l,
    input  logic [3:0] second_h,
    input  logic [3:0] second_l,
    input  logic       alarm_en,
    input  logic       inc_min,
    input  logic       inc_hour,
    input  logic       stop,
    input  logic       snooze,
    output logic [3:0] alarm_hour_h,
    output logic [3:0] alarm_hour_l,
    output logic [3:0] alarm_min_h,
    output logic [3:0] alarm_min_l,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzzer
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RING   = 2'd1;
    localparam logic [1:0] S_SNOOZE = 2'd2;

    localparam logic [15:0] RING_LAST   = 16'(RING_SECONDS);
    localparam logic [15:0] SNOOZE_LAST = 16'(SNOOZE_SECONDS);

    logic [1:0]  r_state;
    logic [3:0]  r_ahh, r_ahl, r_amh, r_aml;
    logic [15:0] r_ring_cnt;
    logic [15:0] r_snz_cnt;
    logic        r_beat;

    logic [3:0]  w_ahh_nx, w_ahl_nx, w_amh_nx, w_aml_nx;
    logic [15:0] w_ring_inc, w_snz_inc;
    logic        w_match;

    assign w_ring_inc = r_ring_cnt + 16'd1;
    assign w_snz_inc  = r_snz_cnt + 16'd1;

    assign w_match = (hour_h == r_ahh) && (hour_l == r_ahl) &&
                     (minute_h == r_amh) && (minute_l == r_aml) &&
                     (second_h == 4'd0) && (second_l == 4'd0);

    // Minutes and hours roll independently; a minute wrap never carries into hours.
    always_comb begin
        w_aml_nx = r_aml;
        w_amh_nx = r_amh;
        if (inc_min) begin
            if (r_aml == 4'd9) begin
                w_aml_nx = 4'd0;
                w_amh_nx = (r_amh == 4'd5) ? 4'd0 : r_amh + 4'd1;
            end else begin
                w_aml_nx = r_aml + 4'd1;
            end
        end
    end

    always_comb begin
        w_ahl_nx = r_ahl;
        w_ahh_nx = r_ahh;
        if (inc_hour) begin
            if (r_ahh == 4'd2 && r_ahl == 4'd3) begin
                w_ahh_nx = 4'd0;
                w_ahl_nx = 4'd0;
            end else if (r_ahl == 4'd9) begin
                w_ahl_nx = 4'd0;
                w_ahh_nx = r_ahh + 4'd1;
            end else begin
                w_ahl_nx = r_ahl + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= S_IDLE;
            r_ahh      <= 4'd0;
            r_ahl      <= 4'd0;
            r_amh      <= 4'd0;
            r_aml      <= 4'd0;
            r_ring_cnt <= 16'd0;
            r_snz_cnt  <= 16'd0;
            r_beat     <= 1'b0;
        end else begin
            r_ahh <= w_ahh_nx;
            r_ahl <= w_ahl_nx;
            r_amh <= w_amh_nx;
            r_aml <= w_aml_nx;
            case (r_state)
                S_IDLE: begin
                    if (alarm_en && !stop && sec_tick && w_match) begin
                        r_state    <= S_RING;
                        r_ring_cnt <= 16'd0;
                        r_beat     <= 1'b1;
                    end
                end
                S_RING: begin
                    if (!alarm_en || stop) begin
                        r_state <= S_IDLE;
                    end else if (snooze) begin
                        r_state   <= S_SNOOZE;
                        r_snz_cnt <= 16'd0;
                    end else if (sec_tick) begin
                        r_ring_cnt <= w_ring_inc;
                        r_beat     <= ~r_beat;
                        if (w_ring_inc == RING_LAST) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (!alarm_en || stop) begin
                        r_state <= S_IDLE;
                    end else if (sec_tick) begin
                        r_snz_cnt <= w_snz_inc;
                        if (w_snz_inc == SNOOZE_LAST) begin
                            r_state    <= S_RING;
                            r_ring_cnt <= 16'd0;
                            r_beat     <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alarm_hour_h = r_ahh;
    assign alarm_hour_l = r_ahl;
    assign alarm_min_h  = r_amh;
    assign alarm_min_l  = r_aml;
    assign ringing      = (r_state == S_RING);
    assign snoozing     = (r_state == S_SNOOZE);
    assign buzzer       = ringing & r_beat;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - bench for alarm_ctrl: setting table, directed ring/snooze sequences, random vs model
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       clr, sec_tick, alarm_en, inc_min, inc_hour, stop, snooze;
    logic [3:0] hour_h, hour_l, minute_h, minute_l, second_h, second_l;
    logic [3:0] alarm_hour_h, alarm_hour_l, alarm_min_h, alarm_min_l;
    logic       ringing, snoozing, buzzer;

    always #5 clk = ~clk;

    alarm_ctrl #(.RING_SECONDS(60), .SNOOZE_SECONDS(300)) dut (
        .clk(clk), .clr(clr), .sec_tick(sec_tick),
        .hour_h(hour_h), .hour_l(hour_l), .minute_h(minute_h), .minute_l(minute_l),
        .second_h(second_h), .second_l(second_l),
        .alarm_en(alarm_en), .inc_min(inc_min), .inc_hour(inc_hour),
        .stop(stop), .snooze(snooze),
        .alarm_hour_h(alarm_hour_h), .alarm_hour_l(alarm_hour_l),
        .alarm_min_h(alarm_min_h), .alarm_min_l(alarm_min_l),
        .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: alarm kept as plain hours/minutes; ring and snooze tracked as elapsed seconds.
    int m_hour = 0, m_min = 0;
    int m_mode = 0;          // 0 idle, 1 ringing, 2 snoozing
    int m_ring_s = 0, m_snz_s = 0;

    function automatic logic [18:0] model_vec();
        return {4'(m_hour / 10), 4'(m_hour % 10), 4'(m_min / 10), 4'(m_min % 10),
                m_mode == 1, m_mode == 2, (m_mode == 1) && (m_ring_s % 2 == 0)};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {alarm_hour_h, alarm_hour_l, alarm_min_h, alarm_min_l, ringing, snoozing, buzzer};
    endfunction

    task automatic model_step();
        bit hit;
        hit = (int'(hour_h) == m_hour / 10) && (int'(hour_l) == m_hour % 10) &&
              (int'(minute_h) == m_min / 10) && (int'(minute_l) == m_min % 10) &&
              second_h == 0 && second_l == 0;
        if (clr) begin
            m_hour = 0; m_min = 0; m_mode = 0; m_ring_s = 0; m_snz_s = 0;
        end else begin
            if (inc_min)  m_min  = (m_min + 1) % 60;
            if (inc_hour) m_hour = (m_hour + 1) % 24;
            if (!alarm_en || stop) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (sec_tick && hit) begin m_mode = 1; m_ring_s = 0; end
            end else if (m_mode == 1) begin
                if (snooze) begin
                    m_mode = 2; m_snz_s = 0;
                end else if (sec_tick) begin
                    m_ring_s++;
                    if (m_ring_s >= 60) m_mode = 0;
                end
            end else if (sec_tick) begin
                m_snz_s++;
                if (m_snz_s >= 300) begin m_mode = 1; m_ring_s = 0; end
            end
        end
    endtask

    task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hour_h = 4'(h / 10); hour_l = 4'(h % 10);
        minute_h = 4'(m / 10); minute_l = 4'(m % 10);
        second_h = 4'(s / 10); second_l = 4'(s % 10);
    endtask

    task automatic tick();
        sec_tick = 1'b1; cycle(); sec_tick = 1'b0;
    endtask

    task automatic trigger_0730();
        set_time(7, 30, 0);
        tick();
        check("ring_entry", {17'd0, ringing, buzzer}, 19'b11);
        set_time(7, 31, 0);
    endtask

    typedef struct {
        logic       clr, inc_h, inc_m;
        int         reps;
        logic [15:0] exp_alarm;
    } vec_t;

    vec_t tbl[9];

    initial begin
        clr = 1'b1; sec_tick = 0; alarm_en = 0; inc_min = 0; inc_hour = 0; stop = 0; snooze = 0;
        set_time(0, 0, 1);

        tbl[0] = '{1'b1, 1'b0, 1'b0, 2,  16'h0000};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 7,  16'h0700};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 30, 16'h0730};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 3,  16'h1033};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 13, 16'h2333};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 26, 16'h2359};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1,  16'h0000};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 24, 16'h0000};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 60, 16'h0000};

        for (int i = 0; i < 9; i++) begin
            clr = tbl[i].clr; inc_hour = tbl[i].inc_h; inc_min = tbl[i].inc_m;
            for (int r = 0; r < tbl[i].reps; r++) cycle();
            clr = 0; inc_hour = 0; inc_min = 0;
            check($sformatf("table_row%0d", i), dut_vec(), {tbl[i].exp_alarm, 3'b000});
        end

        // Alarm 07:30, ring for 60 ticks spaced by idle cycles
        inc_hour = 1; for (int i = 0; i < 7; i++) cycle(); inc_hour = 0;
        inc_min = 1; for (int i = 0; i < 30; i++) cycle(); inc_min = 0;
        check("alarm_0730", dut_vec(), {16'h0730, 3'b000});
        alarm_en = 1;
        set_time(7, 29, 59);
        tick();
        check("no_ring_0729", {18'd0, ringing}, 19'd0);
        trigger_0730();
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k < 60)
                check($sformatf("ring_tick%0d", k), {17'd0, ringing, buzzer}, {17'd0, 1'b1, (k % 2 == 0)});
            else
                check("ring_autostop", {17'd0, ringing, snoozing}, 19'd0);
            cycle();
        end

        // Snooze after 3 ticks, re-ring after 300 ticks, then stop
        trigger_0730();
        for (int k = 0; k < 3; k++) tick();
        snooze = 1; cycle(); snooze = 0;
        check("snooze_entry", {16'd0, ringing, snoozing, buzzer}, 19'b010);
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k == 299) check("snooze_299", {16'd0, ringing, snoozing, buzzer}, 19'b010);
            if (k == 300) check("snooze_rering", {16'd0, ringing, snoozing, buzzer}, 19'b101);
        end
        stop = 1; cycle(); stop = 0;
        check("stop_ring", {16'd0, ringing, snoozing, buzzer}, 19'b000);

        // alarm_en gating
        alarm_en = 0;
        set_time(7, 30, 0);
        tick();
        check("en0_no_ring", {18'd0, ringing}, 19'd0);
        alarm_en = 1;
        trigger_0730();
        cycle();
        alarm_en = 0; cycle(); alarm_en = 1;
        check("en_drop", {18'd0, ringing}, 19'd0);

        // clr mid-snooze with competing pulses
        trigger_0730();
        snooze = 1; cycle(); snooze = 0;
        check("snooze_before_clr", {18'd0, snoozing}, 19'd1);
        clr = 1; snooze = 1; stop = 1; cycle(); clr = 0; snooze = 0; stop = 0;
        check("clr_mid_snooze", dut_vec(), 19'd0);

        // Random traffic against the reference model
        for (int n = 0; n < 4000; n++) begin
            clr      = ($urandom_range(0, 499) == 0);
            inc_min  = ($urandom_range(0, 19) == 0);
            inc_hour = ($urandom_range(0, 19) == 0);
            stop     = ($urandom_range(0, 199) == 0);
            snooze   = ($urandom_range(0, 39) == 0);
            sec_tick = $urandom_range(0, 1);
            alarm_en = ($urandom_range(0, 49) != 0);
            case ($urandom_range(0, 3))
                0: set_time(m_hour, m_min, 0);
                1: begin
                    hour_h = 4'($urandom_range(0, 15)); hour_l = 4'($urandom_range(0, 15));
                    minute_h = 4'($urandom_range(0, 15)); minute_l = 4'($urandom_range(0, 15));
                    second_h = 4'($urandom_range(0, 1)); second_l = 4'($urandom_range(0, 1));
                end
                default: set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 2));
            endcase
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Alarm stage directly downstream of the hour/minute/second BCD counters in the clock top level; consumes the live BCD time and the 1 Hz tick.
- Holds a user-settable alarm time (HH:MM, BCD) and drives a buzzer/ringing indication.
- FSM provides IDLE / RING / SNOOZE behaviour with stop and snooze inputs.
- Alarm-time outputs are exported so the display stage can show them.

Parameters:
- RING_SECONDS, 60, number of sec_tick pulses the alarm rings before auto-stop (1..65535)
- SNOOZE_SECONDS, 300, number of sec_tick pulses spent in snooze before re-ringing (1..65535)

Ports:
- clk  input  1  system clock; single clock domain
- clr  input  1  synchronous, active-high reset
- sec_tick  input  1  one-clk-cycle pulse at 1 Hz, synchronous to clk
- hour_h  input  4  current hour tens, BCD 0..2
- hour_l  input  4  current hour units, BCD 0..9
- minute_h  input  4  current minute tens, BCD 0..5
- minute_l  input  4  current minute units, BCD 0..9
- second_h  input  4  current second tens, BCD 0..5
- second_l  input  4  current second units, BCD 0..9
- alarm_en  input  1  level; 0 forces IDLE and blocks triggering
- inc_min  input  1  one-cycle pulse; increments alarm minutes
- inc_hour  input  1  one-cycle pulse; increments alarm hours
- stop  input  1  one-cycle pulse; cancels ringing/snooze
- snooze  input  1  one-cycle pulse; ring -> snooze
- alarm_hour_h  output  4  alarm hour tens, BCD
- alarm_hour_l  output  4  alarm hour units, BCD
- alarm_min_h  output  4  alarm minute tens, BCD
- alarm_min_l  output  4  alarm minute units, BCD
- ringing  output  1  high while in RING
- snoozing  output  1  high while in SNOOZE
- buzzer  output  1  1 s on / 1 s off pattern while ringing, else 0

Behaviour:
- All state registered on rising clk; clr synchronous, highest priority.
- Reset values: alarm time 00:00, state IDLE, ringing=0, snoozing=0, buzzer=0, all counters 0.
- Alarm-time setting, accepted in every state:
  - inc_min: minutes BCD +1, 59 -> 00, no carry into hours.
  - inc_hour: hours BCD +1, 09 -> 10, 19 -> 20, 23 -> 00.
  - Both asserted in the same cycle: both applied.
  - Updated value is visible on the outputs the next cycle.
- Match = (hour_h, hour_l, minute_h, minute_l) equals the alarm registers AND second_h = 0 AND second_l = 0.
- IDLE -> RING on the clk edge where alarm_en = 1 AND sec_tick = 1 AND match = 1. ringing is high the following cycle.
  - Match is evaluated in IDLE only; match during RING/SNOOZE is ignored.
  - Match with sec_tick low does not trigger.
- On RING entry: ring counter = 0, beat = 1.
- In RING, each sec_tick: ring counter +1 and beat toggles.
  - When a sec_tick brings the ring counter to RING_SECONDS: -> IDLE.
  - buzzer = ringing AND beat.
- RING + snooze -> SNOOZE; snooze counter = 0.
- In SNOOZE, each sec_tick: snooze counter +1.
  - When it reaches SNOOZE_SECONDS: -> RING, with ring counter and beat reinitialised.
- Priority per cycle: clr > alarm_en=0 (-> IDLE) > stop (-> IDLE) > snooze > counter expiry.
  - snooze in IDLE or SNOOZE: ignored.
  - stop in IDLE: no effect.
- Counters: 16-bit unsigned, no wrap possible within the legal parameter range.
- Out-of-range BCD on the time inputs: simply fails to match; no error reporting.
- Latency: every input-to-output effect is 1 clk.

Test Plan:
- Reset, then inc_hour ×7 and inc_min ×30 -> alarm outputs 0,7,3,0.
- Wrap: alarm 23:59, then inc_min and inc_hour pulsed in the same cycle -> 00:00 next cycle.
- Alarm 07:30, alarm_en=1, time 07:29:59 -> 07:30:00 with sec_tick -> ringing=1 one cycle later; buzzer 1,0,1,... per tick; ringing=0 after exactly 60 ticks (RING_SECONDS=60).
- Same trigger, then snooze after 3 ticks -> snoozing=1, buzzer=0; after 300 ticks -> ringing=1 with buzzer=1; then stop -> IDLE next cycle.
- Time 07:30:00 with alarm_en=0 -> no ring. alarm_en dropped mid-RING -> ringing=0 next cycle.
- clr asserted mid-SNOOZE together with snooze/stop pulses -> all outputs at reset values next cycle; alarm time 00:00.
